grostl_sequencer: RTL and testbench
===================================

# grostl_sequencer

Control and chaining-value stage directly upstream of the Grøstl-256 parallel compression datapath.
- Accepts padded 512-bit message blocks over a valid/ready handshake.
- Holds the chaining value H and drives the datapath's `wr`, `round`, `m_in` and `h_in` through 10 rounds per block.
- Captures the datapath's `dout` as the new H and presents the final 512-bit chaining value to the downstream output-transform stage.
- Padding is done upstream. Ω/truncation is done downstream.

## Interface
Parameters:
- `IV`, 512'h0…0100, initial chaining value (Grøstl-256: value 256 in the last 64-bit big-endian word, byte [7][7] = 8'h00, byte [7][6] = 8'h01).
- `ROUNDS`, 10, rounds per compression.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `blk_valid`  in  1  upstream block available.
- `blk_last`  in  1  qualifies `blk_data` as the final block of the message.
- `blk_data`  in  512  padded message block, byte [0][0] = bits 511:504.
- `blk_ready`  out  1  sequencer can accept a block.
- `comp_wr`  out  1  to datapath `wr`.
- `comp_round`  out  4  to datapath `round`.
- `comp_m`  out  512  to datapath `m_in`.
- `comp_h`  out  512  to datapath `h_in`.
- `comp_dout`  in  512  from datapath `dout`.
- `h_valid`  out  1  final chaining value available.
- `h_ready`  in  1  downstream accepts the final value.
- `h_out`  out  512  final chaining value.
- `blk_count`  out  64  blocks compressed in the current message.
- `busy`  out  1  high in RUN or UPDATE.

## Operation
State machine: IDLE, RUN, UPDATE, DONE.

IDLE:
- `blk_ready`=1.
- On `blk_valid && blk_ready`: latch M ← `blk_data` and L ← `blk_last`, set round counter r ← 0, go to RUN.

RUN:
- `comp_wr` = (r==0).
- `comp_round` = r.
- r increments each cycle.
- After the r = ROUNDS-1 cycle, go to UPDATE.

UPDATE:
- H ← `comp_dout`.
- `blk_count` ← `blk_count`+1 (wraps modulo 2^64, no flag).
- Go to DONE if L, else IDLE.

DONE:
- `h_valid`=1 and `h_out`=H, both held stable until `h_ready`.
- On `h_valid && h_ready`: H ← IV, `blk_count` ← 0, go to IDLE.
- `blk_ready`=0 in DONE, so the next message cannot start before the result is consumed.

Data outputs:
- `comp_m` = M and `comp_h` = H at all times. Both are stable for the whole of RUN and UPDATE, because the datapath's `dout` uses `h_in` combinationally.
- Outside RUN: `comp_wr`=0 and `comp_round`=0. The datapath registers free-run and their content is ignored.

Boundary conditions:
- `blk_valid` with `blk_last`=1 as the first block gives a single-block message.
- `blk_data` and `blk_last` are ignored when the handshake does not fire.
- `h_ready` outside DONE is ignored.

Reset (including mid-RUN or mid-DONE), taking effect on the next edge:
- State IDLE, H = IV, M = 0, L = 0, r = 0, `blk_count` = 0.
- All outputs then read `blk_ready`=1, `h_valid`=0, `busy`=0, `comp_wr`=0, `comp_round`=0, `comp_m`=0, `comp_h`=IV, `h_out`=IV.
- Any in-flight block is discarded.

## Timing
Let A be the cycle whose rising edge accepts a block.
- Cycles A+1..A+10: RUN. r = 0..9, `comp_wr`=1 only in A+1.
- Cycle A+11: UPDATE. The datapath register holds round-9 output, so `comp_dout` is valid. H is captured at the end of A+11.
- Cycle A+12: `blk_ready`=1 (non-last block) or `h_valid`=1 (last block).
- Throughput: one block per 12 cycles with back-to-back `blk_valid`.
- Latency, last-block acceptance to `h_valid`: 12 cycles.
- `h_valid` to IDLE: 1 cycle after the `h_ready` handshake edge.

## Structure
`grostl_pkg` holds:
- `grostl_state_t` (512-bit packed [0:7][0:7][7:0]);
- the `GROSTL256_IV` constant;
- `GROSTL_ROUNDS` = 10;
- the `seq_state_e` enum (IDLE, RUN, UPDATE, DONE).

No sub-module. The sequencer does not instantiate the compression datapath; the enclosing top connects the two.

## Test plan
- Reset then idle: `blk_ready`=1, `h_valid`=0, `comp_h`=IV, `blk_count`=0, and the outputs stay so for 20 cycles.
- Single block (padded empty message: byte 0 = 8'h80, last byte = 8'h01, `blk_last`=1), sequencer connected to the datapath:
  - `comp_wr` pulses exactly once at A+1;
  - `comp_round` steps 0..9;
  - `h_valid` rises at A+12;
  - `h_out` matches the golden-model chaining value;
  - `blk_count`=1.
- Three back-to-back blocks, last flagged on the third:
  - accepts occur at cycles A, A+12, A+24;
  - `h_valid` rises at A+36;
  - `blk_count`=3;
  - `h_out` matches the golden model.
- Backpressure: hold `h_ready`=0 for 15 cycles in DONE:
  - `h_out` stays stable and `blk_ready`=0 throughout;
  - after the `h_ready` edge, `comp_h`=IV and `blk_ready`=1 on the next cycle.
- Reset asserted at A+5 mid-RUN: next cycle is IDLE with H=IV and `blk_count`=0; a fresh block then yields the same result as the single-block test.
- Change `blk_data` while in RUN: `comp_m` stays equal to the latched value and the result is unchanged.

Source files
------------

// File: rtl/grostl_pkg.sv
// Shared types and constants for the Groestl-256 compression sequencer.
package grostl_pkg;

  typedef logic [0:7][0:7][7:0] grostl_state_t;

  // Value 256 in the last big-endian 64-bit word: byte [7][6] = 8'h01.
  localparam grostl_state_t GROSTL256_IV = 512'h100;

  localparam int GROSTL_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/grostl_sequencer.sv
// Chaining-value holder and round sequencer feeding the Groestl-256 compression datapath.
// Handshakes: a transfer fires on a rising edge where valid and ready are both high.
module grostl_sequencer
  import grostl_pkg::*;
#(
  parameter grostl_state_t IV     = GROSTL256_IV,
  parameter int            ROUNDS = GROSTL_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  input  logic         blk_last,
  input  logic [511:0] blk_data,
  output logic         blk_ready,
  output logic         comp_wr,
  output logic [3:0]   comp_round,
  output logic [511:0] comp_m,
  output logic [511:0] comp_h,
  input  logic [511:0] comp_dout,
  output logic         h_valid,
  input  logic         h_ready,
  output logic [511:0] h_out,
  output logic [63:0]  blk_count,
  output logic         busy
);

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  seq_state_e    state_q, state_d;
  grostl_state_t h_q, m_q;
  logic          l_q;
  logic [3:0]    r_q;
  logic [63:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (blk_valid) state_d = RUN;
      RUN:     if (r_q == LAST_ROUND) state_d = UPDATE;
      UPDATE:  state_d = l_q ? DONE : IDLE;
      DONE:    if (h_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    blk_ready  = (state_q == IDLE);
    h_valid    = (state_q == DONE);
    busy       = (state_q == RUN) || (state_q == UPDATE);
    comp_wr    = (state_q == RUN) && (r_q == 4'd0);
    comp_round = (state_q == RUN) ? r_q : 4'd0;
  end

  // M and H are only written outside RUN/UPDATE's sensitive window, so the
  // datapath sees stable h_in while dout is combinationally derived from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q   <= IV;
      m_q   <= '0;
      l_q   <= 1'b0;
      r_q   <= 4'd0;
      cnt_q <= 64'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (blk_valid) begin
            m_q <= blk_data;
            l_q <= blk_last;
            r_q <= 4'd0;
          end
        end
        RUN: begin
          r_q <= (r_q == LAST_ROUND) ? 4'd0 : r_q + 4'd1;
        end
        UPDATE: begin
          h_q   <= comp_dout;
          cnt_q <= cnt_q + 64'd1;
        end
        DONE: begin
          if (h_ready) begin
            h_q   <= IV;
            cnt_q <= 64'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign comp_m    = m_q;
  assign comp_h    = h_q;
  assign h_out     = h_q;
  assign blk_count = cnt_q;

endmodule

// File: tb/tb_grostl_sequencer.sv
// Bench for grostl_sequencer with a behavioural stand-in for the compression datapath.
module tb_grostl_sequencer;
  import grostl_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid, blk_last;
  logic [511:0] blk_data;
  logic         blk_ready, comp_wr;
  logic [3:0]   comp_round;
  logic [511:0] comp_m, comp_h, comp_dout, h_out;
  logic         h_valid, h_ready;
  logic [63:0]  blk_count;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [511:0] exp_q[$];
  logic [511:0] exp_h;
  logic [63:0]  exp_cnt;
  logic [511:0] iv_val;
  logic [511:0] dp_st;

  always #5 clk = ~clk;

  grostl_sequencer dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_last(blk_last),
    .blk_data(blk_data), .blk_ready(blk_ready), .comp_wr(comp_wr),
    .comp_round(comp_round), .comp_m(comp_m), .comp_h(comp_h),
    .comp_dout(comp_dout), .h_valid(h_valid), .h_ready(h_ready),
    .h_out(h_out), .blk_count(blk_count), .busy(busy)
  );

  // Toy round function standing in for the P/Q permutations.
  function automatic logic [511:0] round_fn(input logic [511:0] x, input int r);
    logic [511:0] y;
    y = {x[450:0], x[511:451]};
    y = y ^ (y >> 13);
    y[7:0] = y[7:0] ^ 8'(r * 37 + 1);
    return y;
  endfunction

  // Whole compression from the datapath's contract: 10 rounds then feed-forward.
  function automatic logic [511:0] compress(input logic [511:0] h, input logic [511:0] m);
    logic [511:0] x;
    x = h ^ m;
    for (int r = 0; r < GROSTL_ROUNDS; r++) x = round_fn(x, r);
    return x ^ h;
  endfunction

  always @(posedge clk)
    dp_st <= comp_wr ? round_fn(comp_h ^ comp_m, int'(comp_round)) : round_fn(dp_st, int'(comp_round));
  assign comp_dout = dp_st ^ comp_h;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 512'(blk_ready), 512'd1);
    check({tag, "_hvalid"}, 512'(h_valid), 512'd0);
    check({tag, "_busy"}, 512'(busy), 512'd0);
    check({tag, "_wr"}, 512'(comp_wr), 512'd0);
    check({tag, "_round"}, 512'(comp_round), 512'd0);
    check({tag, "_comph"}, comp_h, iv_val);
    check({tag, "_cnt"}, 512'(blk_count), 512'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    blk_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_h = iv_val;
    exp_cnt = 64'd0;
  endtask

  // Called at a negedge in IDLE (or at A+12 of a previous block). Returns at
  // negedge of A+12, or at A+abort if abort is between 1 and 10.
  task automatic send_block(input logic [511:0] data, input logic last,
                            input bit perturb, input bit expect_now, input int abort);
    int waited;
    waited = 0;
    while (!blk_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", 512'(waited), expect_now ? 512'd0 : 512'(waited));
    if (!blk_ready) begin
      $display("FAIL accept_timeout: got blk_ready=0 expected 1");
      errors++;
      return;
    end
    blk_valid = 1'b1;
    blk_data  = data;
    blk_last  = last;
    @(posedge clk);
    #1;
    blk_valid = perturb;
    for (int k = 1; k <= 10; k++) begin
      if (perturb) begin
        blk_data = rand512();
        blk_last = 1'($urandom);
      end
      @(negedge clk);
      if (k == abort) return;
      check($sformatf("run%0d_wr", k), 512'(comp_wr), (k == 1) ? 512'd1 : 512'd0);
      check($sformatf("run%0d_round", k), 512'(comp_round), 512'(k - 1));
      check($sformatf("run%0d_m", k), comp_m, data);
      check($sformatf("run%0d_busy", k), 512'(busy), 512'd1);
      check($sformatf("run%0d_ready", k), 512'(blk_ready), 512'd0);
    end
    blk_valid = 1'b0;
    @(negedge clk);
    check("upd_busy", 512'(busy), 512'd1);
    check("upd_wr", 512'(comp_wr), 512'd0);
    check("upd_hvalid", 512'(h_valid), 512'd0);
    exp_h = compress(exp_h, data);
    exp_cnt = exp_cnt + 64'd1;
    @(negedge clk);
    check("a12_cnt", 512'(blk_count), 512'(exp_cnt));
    check("a12_busy", 512'(busy), 512'd0);
    if (last) begin
      check("a12_hvalid", 512'(h_valid), 512'd1);
      check("a12_ready", 512'(blk_ready), 512'd0);
      exp_q.push_back(exp_h);
    end else begin
      check("a12_ready", 512'(blk_ready), 512'd1);
      check("a12_hvalid", 512'(h_valid), 512'd0);
      check("a12_comph", comp_h, exp_h);
    end
  endtask

  // Called at a negedge in DONE; holds h_ready low for `hold` cycles.
  task automatic finish_msg(input int hold);
    logic [511:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~h_out;
    for (int i = 0; i <= hold; i++) begin
      blk_valid = 1'($urandom);
      blk_data  = rand512();
      check("done_hvalid", 512'(h_valid), 512'd1);
      check("done_hout", h_out, exp);
      check("done_ready", 512'(blk_ready), 512'd0);
      check("done_cnt", 512'(blk_count), 512'(exp_cnt));
      if (i < hold) @(negedge clk);
    end
    h_ready = 1'b1;
    @(posedge clk);
    #1;
    h_ready = 1'b0;
    blk_valid = 1'b0;
    exp_h = iv_val;
    exp_cnt = 64'd0;
    @(negedge clk);
    check_idle_outputs("release");
  endtask

  initial begin
    logic [511:0] empty_blk, single_res;
    logic [511:0] b[3];
    int n;
    iv_val = GROSTL256_IV;
    rst = 1'b1; blk_valid = 1'b0; blk_last = 1'b0; blk_data = '0; h_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Idle for 20 cycles, with h_ready toggling (must be ignored).
    check("rst_compm", comp_m, 512'd0);
    check("rst_hout", h_out, iv_val);
    for (int i = 0; i < 20; i++) begin
      h_ready = 1'($urandom);
      blk_data = rand512();
      blk_last = 1'($urandom);
      @(negedge clk);
      check_idle_outputs("idle");
    end
    h_ready = 1'b0;

    // Padded empty message as a single block.
    empty_blk = '0;
    empty_blk[511:504] = 8'h80;
    empty_blk[7:0] = 8'h01;
    send_block(empty_blk, 1'b1, 1'b0, 1'b1, 0);
    single_res = exp_h;
    finish_msg(0);

    // Three back-to-back blocks, with a 15-cycle DONE backpressure.
    for (int i = 0; i < 3; i++) b[i] = rand512();
    for (int i = 0; i < 3; i++) send_block(b[i], (i == 2), 1'b0, 1'b1, 0);
    finish_msg(15);

    // Reset mid-RUN of a second block, then the single-block result again.
    send_block(rand512(), 1'b0, 1'b0, 1'b1, 0);
    send_block(rand512(), 1'b1, 1'b0, 1'b1, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_h = iv_val;
    exp_cnt = 64'd0;
    check_idle_outputs("midrun_rst");
    check("midrun_rst_m", comp_m, 512'd0);
    send_block(empty_blk, 1'b1, 1'b0, 1'b1, 0);
    check("rerun_same", exp_h, single_res);
    finish_msg(2);

    // Reset in DONE discards the pending result.
    send_block(rand512(), 1'b1, 1'b0, 1'b1, 0);
    void'(exp_q.pop_back());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_h = iv_val;
    exp_cnt = 64'd0;
    check_idle_outputs("done_rst");
    check("done_rst_hout", h_out, iv_val);

    // Input changes during RUN must not disturb the latched block.
    send_block(empty_blk, 1'b1, 1'b1, 1'b1, 0);
    check("perturb_same", exp_h, single_res);
    finish_msg(1);

    // Randomized messages of 1..4 blocks with random idle gaps and holds.
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 4);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      for (int i = 0; i < n; i++) send_block(rand512(), (i == n - 1), 1'($urandom), 1'b1, 0);
      finish_msg($urandom_range(0, 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
